// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to a single UART transmitter.
// Optional transaction watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
`ifndef NUM_DATA_BITS
`define NUM_DATA_BITS 8
`endif

// state     | meaning
// IDLE      | no transaction; grant the next requester in round-robin order
// ISSUE     | character latched; tx_write pulse is being launched
// WAIT_BUSY | waiting for the transmitter to report busy
// WAIT_DONE | waiting for the transmitter to report frame done
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = `NUM_DATA_BITS,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      baud,
  input  logic                      reset,
  input  logic                      arb_enable,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        cpl,
  output logic                      cpl_err,
  output logic                      arb_busy,
  output logic                      tx_enable,
  output logic                      tx_write,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  input  logic                      tx_error
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   sel_next;
  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic               to_hit;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int j;
    j          = 0;
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[IDX_W'(j)]) begin
        pick_valid = 1'b1;
        pick       = IDX_W'(j);
      end
    end
  end

  assign sel_next = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  assign arb_busy = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             to_kill;
  logic             in_wait;

  assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign to_hit  = in_wait && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // to_kill mirrors the FSM's timeout branch so the transmitter reset lines up with cpl.
  always_ff @(posedge baud) begin
    if (reset) begin
      to_cnt  <= '0;
      to_kill <= 1'b0;
    end else begin
      to_kill <= to_hit && arb_enable && !tx_done;
      if (state == IDLE) to_cnt <= '0;
      else if (in_wait)  to_cnt <= to_cnt + 1'b1;
    end
  end

  assign tx_enable = arb_enable && !reset && !to_kill;
`else
  assign to_hit    = 1'b0;
  assign tx_enable = arb_enable && !reset;
`endif

  always_ff @(posedge baud) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      sel      <= '0;
      tx_data  <= '0;
      ack      <= '0;
      cpl      <= '0;
      cpl_err  <= 1'b0;
      tx_write <= 1'b0;
    end else begin
      ack      <= '0;
      cpl      <= '0;
      cpl_err  <= 1'b0;
      tx_write <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_enable && pick_valid) begin
            sel       <= pick;
            tx_data   <= data_arr[pick];
            ack[pick] <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!arb_enable) begin
            cpl[sel] <= 1'b1;
            cpl_err  <= 1'b1;
            state    <= IDLE;
          end else begin
            tx_write <= 1'b1;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (!arb_enable) begin
            cpl[sel] <= 1'b1;
            cpl_err  <= 1'b1;
            state    <= IDLE;
          end else if (tx_done) begin
            cpl[sel] <= 1'b1;
            cpl_err  <= tx_error;
            rr_ptr   <= sel_next;
            state    <= IDLE;
          end else if (to_hit) begin
            cpl[sel] <= 1'b1;
            cpl_err  <= 1'b1;
            rr_ptr   <= sel_next;
            state    <= IDLE;
          end else if (state == WAIT_BUSY && tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; expected values are hand-derived from the cycle timing.
// Covers the watchdog path when UART_ARB_TIMEOUT_EN is defined, the indefinite wait otherwise.
module tb_uart_tx_arbiter;

  logic        baud = 1'b0;
  logic        reset;
  logic        arb_enable;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  cpl;
  logic        cpl_err;
  logic        arb_busy;
  logic        tx_enable;
  logic        tx_write;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_error;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
    .baud(baud), .reset(reset), .arb_enable(arb_enable), .req(req), .req_data(req_data),
    .ack(ack), .cpl(cpl), .cpl_err(cpl_err), .arb_busy(arb_busy), .tx_enable(tx_enable),
    .tx_write(tx_write), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #5 baud = ~baud;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge baud);
    #1;
  endtask

  // One full transaction starting from IDLE with the request already applied.
  task automatic do_txn(input logic [3:0] exp_g, input logic [7:0] exp_d,
                        input logic err, input logic skip_busy);
    tick();
    chk("ack", ack, exp_g);
    chk("busy_on", arb_busy, 1);
    tick();
    chk("tx_write", tx_write, 1);
    chk("tx_data", tx_data, exp_d);
    chk("ack_one_shot", ack, 0);
    if (!skip_busy) begin
      tx_busy = 1'b1;
      tick();
      chk("tx_write_one_shot", tx_write, 0);
      tick();
      chk("no_early_cpl", cpl, 0);
      tx_busy = 1'b0;
    end
    tx_done  = 1'b1;
    tx_error = err;
    tick();
    tx_done  = 1'b0;
    tx_error = 1'b0;
    chk("cpl", cpl, exp_g);
    chk("cpl_err", cpl_err, err);
    chk("busy_off", arb_busy, 0);
    chk("no_grant_in_cpl", ack, 0);
    chk("tx_data_hold", tx_data, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset      = 1'b1;
    arb_enable = 1'b1;
    req        = 4'b0000;
    req_data   = {8'h3C, 8'hA5, 8'h69, 8'h0F};
    tx_busy    = 1'b0;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    tick();
    tick();
    chk("rst_ack", ack, 0);
    chk("rst_cpl", cpl, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_tx_write", tx_write, 0);
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    tick();
    chk("tx_enable_run", tx_enable, 1);

    // single request to requester 2
    req = 4'b0100;
    do_txn(4'b0100, 8'hA5, 1'b0, 1'b0);
    req = 4'b0000;

    // wrap from rr_ptr=3, second frame finishes while still in WAIT_BUSY
    req = 4'b1001;
    do_txn(4'b1000, 8'h3C, 1'b0, 1'b0);
    do_txn(4'b0001, 8'h0F, 1'b0, 1'b1);
    req = 4'b0000;

    // transmitter error reported with done
    req = 4'b0010;
    do_txn(4'b0010, 8'h69, 1'b1, 1'b0);
    req = 4'b0000;

    // abort by dropping arb_enable in WAIT_DONE (rr_ptr=2, so scan 2,3,0 picks 0)
    req = 4'b0001;
    tick();
    chk("abort_ack", ack, 4'b0001);
    req = 4'b0000;
    tick();
    chk("abort_tx_write", tx_write, 1);
    tx_busy = 1'b1;
    tick();
    arb_enable = 1'b0;
    #1;
    chk("abort_tx_enable_low", tx_enable, 0);
    tick();
    chk("abort_cpl", cpl, 4'b0001);
    chk("abort_cpl_err", cpl_err, 1);
    chk("abort_idle", arb_busy, 0);
    tx_busy = 1'b0;
    req = 4'b1111;
    tick();
    tick();
    chk("disabled_no_ack", ack, 0);
    chk("disabled_idle", arb_busy, 0);
    arb_enable = 1'b1;
    do_txn(4'b0100, 8'hA5, 1'b0, 1'b0);
    req = 4'b0000;

    // reset while in WAIT_DONE (rr_ptr=3, so scan 3,0 picks 0)
    req = 4'b0001;
    tick();
    chk("rst_txn_ack", ack, 4'b0001);
    req = 4'b0000;
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    chk("rst_txn_busy", arb_busy, 1);
    reset = 1'b1;
    tick();
    chk("midrst_cpl", cpl, 0);
    chk("midrst_cpl_err", cpl_err, 0);
    chk("midrst_busy", arb_busy, 0);
    chk("midrst_tx_write", tx_write, 0);
    chk("midrst_tx_enable", tx_enable, 0);
    chk("midrst_tx_data", tx_data, 0);
    tx_busy = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_rst_cpl", cpl, 0);

    // contention after reset: 0,1,2,3,0
    req = 4'b1111;
    do_txn(4'b0001, 8'h0F, 1'b0, 1'b0);
    do_txn(4'b0010, 8'h69, 1'b0, 1'b0);
    do_txn(4'b0100, 8'hA5, 1'b0, 1'b0);
    do_txn(4'b1000, 8'h3C, 1'b0, 1'b0);
    do_txn(4'b0001, 8'h0F, 1'b0, 1'b0);
    req = 4'b0000;

    // transmitter never completes (rr_ptr=1)
    req = 4'b0010;
    tick();
    chk("to_ack", ack, 4'b0010);
    req = 4'b0000;
    tick();
    chk("to_tx_write", tx_write, 1);
    tx_busy = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
    repeat (7) tick();
    chk("to_not_yet", cpl, 0);
    tick();
    chk("to_cpl", cpl, 4'b0010);
    chk("to_cpl_err", cpl_err, 1);
    chk("to_tx_enable_low", tx_enable, 0);
    chk("to_idle", arb_busy, 0);
    tx_busy = 1'b0;
    tick();
    chk("to_tx_enable_back", tx_enable, 1);
    chk("to_cpl_one_shot", cpl, 0);
`else
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (cpl != 4'b0000) seen = 1'b1;
    end
    chk("hang_no_cpl", seen, 0);
    chk("hang_busy", arb_busy, 1);
    chk("hang_tx_enable", tx_enable, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
